// File: rtl/cnt_hist.sv
// cnt_hist: builds a per-frame histogram of gray_data symbols 1..6 as {count, one-hot flag} words.
// Optional feature: define CNT_ERR_CHK_EN to add the sticky sym_err output.
module cnt_hist #(
    parameter int NUM_SYM = 100,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_valid,
    input  logic [7:0]    gray_data,
    output logic [CW+6:0] CNT1,
    output logic [CW+6:0] CNT2,
    output logic [CW+6:0] CNT3,
    output logic [CW+6:0] CNT4,
    output logic [CW+6:0] CNT5,
    output logic [CW+6:0] CNT6,
    output logic          CNT_valid,
    output logic          busy
`ifdef CNT_ERR_CHK_EN
    ,
    output logic          sym_err
`endif
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] samp;
    logic [CW-1:0] cnt [6];
    logic start, last;
    // any sample taken outside COUNT opens a new frame, which lets DONE chain straight into the next one
    assign start = gray_valid && state != COUNT;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        last = gray_valid && (start ? NUM_SYM == 1 : samp == 8'(NUM_SYM - 1));
        state_nx = last ? DONE : start ? COUNT : state == DONE ? IDLE : state;
        CNT_valid = state == DONE;
        busy = state == COUNT;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) samp <= '0;
        else if (start) samp <= 8'd1;
        else if (gray_valid) samp <= samp + 8'd1;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (start) cnt[i] <= CW'(gray_data == 8'(i + 1));
                else if (gray_valid && gray_data == 8'(i + 1) && cnt[i] != '1) cnt[i] <= cnt[i] + CW'(1);
        end
    assign CNT1 = {cnt[0], 7'h20};
    assign CNT2 = {cnt[1], 7'h10};
    assign CNT3 = {cnt[2], 7'h08};
    assign CNT4 = {cnt[3], 7'h04};
    assign CNT5 = {cnt[4], 7'h02};
    assign CNT6 = {cnt[5], 7'h01};
`ifdef CNT_ERR_CHK_EN
    logic legal;
    assign legal = gray_data >= 8'd1 && gray_data <= 8'd6;
    always_ff @(posedge clk or posedge reset)
        if (reset) sym_err <= 1'b0;
        else if (start) sym_err <= !legal;
        else if (gray_valid && !legal) sym_err <= 1'b1;
`endif
endmodule

// File: tb/tb_cnt_hist.sv
// tb_cnt_hist: directed frames for cnt_hist; expected histograms are queued and checked when CNT_valid fires.
module tb_cnt_hist;
    logic clk = 1'b0;
    logic reset, gray_valid;
    logic [7:0] gray_data;
    logic [14:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic CNT_valid, busy;
`ifdef CNT_ERR_CHK_EN
    logic sym_err;
`endif
    typedef struct {
        logic [5:0][14:0] c;
        int at;
    } exp_t;
    exp_t q[$];
    int nchk = 0, nfail = 0, ncyc = 0;

    cnt_hist dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
        .CNT_valid(CNT_valid), .busy(busy)
`ifdef CNT_ERR_CHK_EN
        , .sym_err(sym_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0][14:0] mk(input logic [14:0] a, b, c, d, e, f);
        logic [5:0][14:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    task automatic push_exp(input logic [5:0][14:0] c);
        exp_t e;
        e.c = c;
        e.at = ncyc + 1;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] s);
        gray_valid = 1'b1;
        gray_data = s;
        @(posedge clk);
        #1;
        gray_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] sym2(input int i);
        return i < 10 ? 8'd1 : i < 30 ? 8'd2 : i < 60 ? 8'd3 : i < 75 ? 8'd4 : i < 90 ? 8'd5 : 8'd6;
    endfunction

    always @(negedge clk) begin
        logic [5:0][14:0] act;
        exp_t e;
        ncyc++;
        if (CNT_valid) begin
            act = mk(CNT1, CNT2, CNT3, CNT4, CNT5, CNT6);
            if (q.size() == 0) begin
                chk("unexpected_cnt_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("cnt_valid_cycle", ncyc, e.at);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                for (int i = 0; i < 6; i++) chk($sformatf("cnt%0d", i + 1), {17'd0, act[i]}, {17'd0, e.c[i]});
            end
        end
    end

    initial begin
        reset = 1'b1;
        gray_valid = 1'b0;
        gray_data = 8'd0;
        idle(2);
        chk("rst_cnt1", {17'd0, CNT1}, 32'h0020);
        chk("rst_cnt2", {17'd0, CNT2}, 32'h0010);
        chk("rst_cnt6", {17'd0, CNT6}, 32'h0001);
        chk("rst_cnt_valid", {31'd0, CNT_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(2);
        // contiguous frame, then a back-to-back frame of all 3s starting in the DONE cycle
        for (int i = 0; i < 100; i++) send(sym2(i));
        push_exp(mk(15'h0520, 15'h0A10, 15'h0F08, 15'h0784, 15'h0782, 15'h0501));
        for (int i = 0; i < 100; i++) send(8'd3);
        push_exp(mk(15'h0020, 15'h0010, 15'h3208, 15'h0004, 15'h0002, 15'h0001));
        idle(3);
        chk("stable_after_done", {17'd0, CNT3}, 32'h3208);
        // same data as the first frame with random gaps
        for (int i = 0; i < 100; i++) begin
            send(sym2(i));
            if (i < 99) begin
                int g = $urandom_range(0, 3);
                repeat (g) begin
                    chk("busy_gap", {31'd0, busy}, 32'd1);
                    idle(1);
                end
                chk("busy_frame", {31'd0, busy}, 32'd1);
            end
        end
        push_exp(mk(15'h0520, 15'h0A10, 15'h0F08, 15'h0784, 15'h0782, 15'h0501));
        idle(3);
        // reset mid-frame aborts without CNT_valid
        for (int i = 0; i < 50; i++) send(sym2(i));
        reset = 1'b1;
        #1;
        chk("abort_cnt2", {17'd0, CNT2}, 32'h0010);
        chk("abort_cnt3", {17'd0, CNT3}, 32'h0008);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 100; i++) send(i < 50 ? 8'd4 : 8'd6);
        push_exp(mk(15'h0020, 15'h0010, 15'h0008, 15'h1904, 15'h0002, 15'h1901));
        idle(3);
        // illegal 7s occupy frame slots but count nowhere
        for (int i = 0; i < 100; i++) begin
            send((i % 20 == 10) ? 8'd7 : 8'd1);
`ifdef CNT_ERR_CHK_EN
            chk("sym_err", {31'd0, sym_err}, {31'd0, i >= 10});
`endif
        end
        push_exp(mk(15'h2FA0, 15'h0010, 15'h0008, 15'h0004, 15'h0002, 15'h0001));
        idle(3);
        send(8'd2);
`ifdef CNT_ERR_CHK_EN
        chk("sym_err_clear", {31'd0, sym_err}, 32'd0);
`endif
        chk("new_frame_busy", {31'd0, busy}, 32'd1);
        idle(3);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule
